// File: rtl/bht_nbit_gshare_if.sv
// Lookup/update bus for the N-bit gshare branch history table.
// Perf counter signals exist only when BHT_PERF_COUNTERS_EN is defined.
interface bht_nbit_gshare_if #(
   parameter int PC_W      = 9,
   parameter int ADDR_BITS = 4,
   parameter int H         = 4
);
   logic                 lookup_valid;
   logic [PC_W-1:0]      lookup_pc;
   logic                 pred_valid;
   logic                 prediction;
   logic [ADDR_BITS-1:0] pred_index;
   logic                 upd_valid;
   logic [ADDR_BITS-1:0] upd_index;
   logic                 upd_taken;
   logic                 upd_pred;
   logic [H-1:0]         ghr;
`ifdef BHT_PERF_COUNTERS_EN
   logic [31:0]          perf_lookups;
   logic [31:0]          perf_mispredicts;
`endif

   modport master (
      output lookup_valid, lookup_pc, upd_valid, upd_index, upd_taken, upd_pred,
      input  pred_valid, prediction, pred_index, ghr
`ifdef BHT_PERF_COUNTERS_EN
      , input perf_lookups, perf_mispredicts
`endif
   );

   modport slave (
      input  lookup_valid, lookup_pc, upd_valid, upd_index, upd_taken, upd_pred,
      output pred_valid, prediction, pred_index, ghr
`ifdef BHT_PERF_COUNTERS_EN
      , output perf_lookups, perf_mispredicts
`endif
   );
endinterface

// File: rtl/bht_nbit_gshare.sv
// M-entry table of N-bit saturating counters, bimodal or gshare indexed, with a
// non-speculative H-bit GHR. Optional perf counters: define BHT_PERF_COUNTERS_EN.
module bht_nbit_gshare_cell #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic         taken,
   output logic [N-1:0] ctr
);
   localparam logic [N-1:0] WNT = N'((2 ** (N - 1)) - 1);
   localparam logic [N-1:0] MAX = '1;

   always_ff @(posedge clk) begin
      if (reset)
         ctr <= WNT;
      else if (wr_en) begin
         if (taken && ctr != MAX)
            ctr <= ctr + 1'b1;
         else if (!taken && ctr != '0)
            ctr <= ctr - 1'b1;
      end
   end
endmodule

module bht_nbit_gshare #(
   parameter int M    = 16,
   parameter int N    = 2,
   parameter int H    = 4,
   parameter int PC_W = 9,
   parameter int MODE = 1
) (
   input logic            clk,
   input logic            reset,
   bht_nbit_gshare_if.slave bus
);
   localparam int ADDR_BITS = $clog2(M);

   logic [M-1:0][N-1:0]  ctr;
   logic [ADDR_BITS-1:0] pc_idx;
   logic [ADDR_BITS-1:0] idx;
   logic [H-1:0]         ghr_q;
   logic [H-1:0]         ghr_next;
   logic                 pred_valid_q;
   logic                 pred_q;
   logic [ADDR_BITS-1:0] idx_q;

   assign pc_idx = bus.lookup_pc[ADDR_BITS-1:0];

   generate
      if (MODE == 1) begin : g_gshare
         logic [ADDR_BITS-1:0] ghr_ext;
         assign ghr_ext = ADDR_BITS'(ghr_q);
         assign idx     = pc_idx ^ ghr_ext;
      end else begin : g_bimodal
         assign idx = pc_idx;
      end

      if (H == 1) begin : g_ghr1
         assign ghr_next = bus.upd_taken;
      end else begin : g_ghrn
         assign ghr_next = {ghr_q[H-2:0], bus.upd_taken};
      end

      // One counter per entry; only the addressed entry sees a write strobe.
      for (genvar g = 0; g < M; g++) begin : g_ent
         bht_nbit_gshare_cell #(.N(N)) u_cell (
            .clk   (clk),
            .reset (reset),
            .wr_en (bus.upd_valid && (bus.upd_index == ADDR_BITS'(g))),
            .taken (bus.upd_taken),
            .ctr   (ctr[g])
         );
      end
   endgenerate

   // Reads the pre-update counter: cell writes land on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         pred_valid_q <= 1'b0;
         pred_q       <= 1'b0;
         idx_q        <= '0;
      end else begin
         pred_valid_q <= bus.lookup_valid;
         if (bus.lookup_valid) begin
            idx_q  <= idx;
            pred_q <= ctr[idx][N-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         ghr_q <= '0;
      else if (bus.upd_valid)
         ghr_q <= ghr_next;
   end

   assign bus.pred_valid = pred_valid_q;
   assign bus.prediction = pred_q;
   assign bus.pred_index = idx_q;
   assign bus.ghr        = ghr_q;

`ifdef BHT_PERF_COUNTERS_EN
   logic [31:0] lookups_q;
   logic [31:0] mispredicts_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         lookups_q     <= '0;
         mispredicts_q <= '0;
      end else begin
         if (bus.lookup_valid)
            lookups_q <= lookups_q + 32'd1;
         if (bus.upd_valid && (bus.upd_pred != bus.upd_taken))
            mispredicts_q <= mispredicts_q + 32'd1;
      end
   end

   assign bus.perf_lookups     = lookups_q;
   assign bus.perf_mispredicts = mispredicts_q;
`endif
endmodule

// File: tb/tb_bht_nbit_gshare.sv
// Directed bench: gshare table (M16/N2/H4), bimodal table, and 1-bit table.
module tb_bht_nbit_gshare;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   bht_nbit_gshare_if #(.PC_W(9), .ADDR_BITS(4), .H(4)) bus_a ();
   bht_nbit_gshare_if #(.PC_W(9), .ADDR_BITS(4), .H(4)) bus_b ();
   bht_nbit_gshare_if #(.PC_W(9), .ADDR_BITS(3), .H(3)) bus_c ();

   bht_nbit_gshare #(.M(16), .N(2), .H(4), .PC_W(9), .MODE(1)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave));
   bht_nbit_gshare #(.M(16), .N(2), .H(4), .PC_W(9), .MODE(0)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave));
   bht_nbit_gshare #(.M(8), .N(1), .H(3), .PC_W(9), .MODE(0)) dut_c (
      .clk(clk), .reset(reset), .bus(bus_c.slave));

   typedef struct {
      logic       lv;
      logic [8:0] pc;
      logic       uv;
      logic [3:0] ui;
      logic       ut;
      logic       e_pv;
      logic       e_pred;
      logic [3:0] e_idx;
      logic [3:0] e_ghr;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic sweep_wnt(input string tag);
      for (int pc = 0; pc < 16; pc++) begin
         bus_a.lookup_valid = 1'b1;
         bus_a.lookup_pc    = 9'(pc);
         tick();
         check({tag, "_pv"},   32'(bus_a.pred_valid), 32'd1);
         check({tag, "_pred"}, 32'(bus_a.prediction), 32'd0);
         check({tag, "_idx"},  32'(bus_a.pred_index), 32'(pc));
         check({tag, "_ghr"},  32'(bus_a.ghr),        32'd0);
      end
      bus_a.lookup_valid = 1'b0;
   endtask

   task automatic b_upd(input logic t);
      bus_b.upd_valid = 1'b1;
      bus_b.upd_index = 4'd3;
      bus_b.upd_taken = t;
      tick();
      bus_b.upd_valid = 1'b0;
   endtask

   task automatic b_look(input logic [8:0] pc, input logic exp, input string nm);
      bus_b.lookup_valid = 1'b1;
      bus_b.lookup_pc    = pc;
      tick();
      bus_b.lookup_valid = 1'b0;
      check({nm, "_pv"},   32'(bus_b.pred_valid), 32'd1);
      check({nm, "_pred"}, 32'(bus_b.prediction), 32'(exp));
      check({nm, "_idx"},  32'(bus_b.pred_index), 32'd3);
   endtask

   task automatic c_upd(input logic [2:0] i, input logic p, input logic t);
      bus_c.upd_valid = 1'b1;
      bus_c.upd_index = i;
      bus_c.upd_pred  = p;
      bus_c.upd_taken = t;
      tick();
      bus_c.upd_valid = 1'b0;
   endtask

   task automatic c_look(input logic [2:0] i, input logic exp, input string nm);
      bus_c.lookup_valid = 1'b1;
      bus_c.lookup_pc    = {6'b101000, i};
      tick();
      bus_c.lookup_valid = 1'b0;
      check({nm, "_pred"}, 32'(bus_c.prediction), 32'(exp));
      check({nm, "_idx"},  32'(bus_c.pred_index), 32'(i));
   endtask

   initial begin
      //          lv    pc      uv    ui  ut    pv    pred  idx    ghr
      vecs[0] = '{1'b0, 9'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd15, 4'b0001};
      vecs[1] = '{1'b0, 9'h000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd15, 4'b0010};
      vecs[2] = '{1'b0, 9'h000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd15, 4'b0101};
      vecs[3] = '{1'b0, 9'h000, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd15, 4'b1011};
      vecs[4] = '{1'b1, 9'h005, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd14, 4'b1011};
      vecs[5] = '{1'b1, 9'h1F5, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd14, 4'b1011};
      vecs[6] = '{1'b1, 9'h00B, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0,  4'b1011};
      vecs[7] = '{1'b1, 9'h009, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2,  4'b1011};
      vecs[8] = '{1'b1, 9'h00A, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd1,  4'b0111};
      vecs[9] = '{1'b0, 9'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1,  4'b0111};

      bus_a.lookup_valid = 0; bus_a.lookup_pc = '0; bus_a.upd_valid = 0;
      bus_a.upd_index = '0; bus_a.upd_taken = 0; bus_a.upd_pred = 0;
      bus_b.lookup_valid = 0; bus_b.lookup_pc = '0; bus_b.upd_valid = 0;
      bus_b.upd_index = '0; bus_b.upd_taken = 0; bus_b.upd_pred = 0;
      bus_c.lookup_valid = 0; bus_c.lookup_pc = '0; bus_c.upd_valid = 0;
      bus_c.upd_index = '0; bus_c.upd_taken = 0; bus_c.upd_pred = 0;

      tick();
      reset = 1'b0;
      check("rst_pv",   32'(bus_a.pred_valid), 32'd0);
      check("rst_pred", 32'(bus_a.prediction), 32'd0);
      check("rst_idx",  32'(bus_a.pred_index), 32'd0);
      check("rst_ghr",  32'(bus_a.ghr),        32'd0);

      sweep_wnt("wnt");

      foreach (vecs[k]) begin
         bus_a.lookup_valid = vecs[k].lv;
         bus_a.lookup_pc    = vecs[k].pc;
         bus_a.upd_valid    = vecs[k].uv;
         bus_a.upd_index    = vecs[k].ui;
         bus_a.upd_taken    = vecs[k].ut;
         tick();
         check($sformatf("v%0d_pv", k),   32'(bus_a.pred_valid), 32'(vecs[k].e_pv));
         check($sformatf("v%0d_pred", k), 32'(bus_a.prediction), 32'(vecs[k].e_pred));
         check($sformatf("v%0d_idx", k),  32'(bus_a.pred_index), 32'(vecs[k].e_idx));
         check($sformatf("v%0d_ghr", k),  32'(bus_a.ghr),        32'(vecs[k].e_ghr));
      end
      bus_a.lookup_valid = 0;
      bus_a.upd_valid    = 0;

      // Collision: ghr=0111, counter[7]=1; pc 0 hashes to entry 7.
      bus_a.lookup_valid = 1; bus_a.lookup_pc = 9'h000;
      bus_a.upd_valid = 1; bus_a.upd_index = 4'd7; bus_a.upd_taken = 1;
      tick();
      bus_a.upd_valid = 0;
      check("col_pred", 32'(bus_a.prediction), 32'd0);
      check("col_idx",  32'(bus_a.pred_index), 32'd7);
      check("col_ghr",  32'(bus_a.ghr),        32'hF);
      bus_a.lookup_pc = 9'h008;
      tick();
      bus_a.lookup_valid = 0;
      check("col_next_pred", 32'(bus_a.prediction), 32'd1);
      check("col_next_idx",  32'(bus_a.pred_index), 32'd7);

      // Reset wins over a same-cycle lookup and update.
      bus_a.lookup_valid = 1; bus_a.lookup_pc = 9'h00B;
      bus_a.upd_valid = 1; bus_a.upd_index = 4'd5; bus_a.upd_taken = 1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus_a.lookup_valid = 0; bus_a.upd_valid = 0;
      check("mrst_pv",   32'(bus_a.pred_valid), 32'd0);
      check("mrst_pred", 32'(bus_a.prediction), 32'd0);
      check("mrst_idx",  32'(bus_a.pred_index), 32'd0);
      check("mrst_ghr",  32'(bus_a.ghr),        32'd0);
      sweep_wnt("mrst");

      // Bimodal saturation on entry 3.
      b_upd(1);
      b_look(9'h003, 1'b1, "sat_up1");
      b_upd(1); b_upd(1); b_upd(1);
      b_look(9'h1F3, 1'b1, "sat_top");
      b_upd(0);
      b_look(9'h003, 1'b1, "sat_dn1");
      b_upd(0);
      b_look(9'h003, 1'b0, "sat_dn2");
      for (int j = 0; j < 5; j++) b_upd(0);
      b_upd(1);
      b_look(9'h003, 1'b0, "sat_floor");
      check("sat_ghr", 32'(bus_b.ghr), 32'd1);

      // 1-bit table.
      c_look(3'd0, 1'b0, "n1_l0");
      c_look(3'd1, 1'b0, "n1_l1");
      c_look(3'd2, 1'b0, "n1_l2");
      c_upd(3'd1, 1'b0, 1'b1);
      c_upd(3'd2, 1'b1, 1'b1);
`ifdef BHT_PERF_COUNTERS_EN
      check("perf_lookups",     bus_c.perf_lookups,     32'd3);
      check("perf_mispredicts", bus_c.perf_mispredicts, 32'd1);
`endif
      c_look(3'd1, 1'b1, "n1_t1");
      c_upd(3'd2, 1'b0, 1'b1);
      c_look(3'd2, 1'b1, "n1_sat");
      c_upd(3'd1, 1'b1, 1'b0);
      c_look(3'd1, 1'b0, "n1_nt");
      check("n1_ghr", 32'(bus_c.ghr), 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bht_nbit_gshare.md
Name: bht_nbit_gshare

Overview:
- Parametrised branch history table: M entries of N-bit saturating counters, with a selectable index mode (bimodal or gshare) and an H-bit global history register (GHR).
- Sits in fetch: the lookup port takes a PC and returns a registered prediction plus the table index used.
- The update port is written at branch resolution with that index and the actual outcome.
- Generalises the 1-bit/2-bit predictor table to any counter width, adds history hashing, and separates the lookup and update paths.

Parameters:
- M, 16, table entries; power of two, >= 2; ADDR_BITS = clog2(M).
- N, 2, counter width in bits; 1..4.
- H, 4, GHR width; 1..ADDR_BITS.
- PC_W, 9, PC width; >= ADDR_BITS.
- MODE, 1, index mode; 0 = bimodal (pc only), 1 = gshare (pc XOR GHR).

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high reset.
- lookup_valid, input, 1, lookup request this cycle.
- lookup_pc, input, PC_W, PC of the branch being predicted.
- pred_valid, output, 1, registered; high one cycle after lookup_valid.
- prediction, output, 1, registered; predicted taken = counter MSB.
- pred_index, output, ADDR_BITS, registered index used for the lookup; returned on update.
- upd_valid, input, 1, branch resolution this cycle.
- upd_index, input, ADDR_BITS, entry to train (pred_index from the lookup).
- upd_taken, input, 1, actual outcome.
- upd_pred, input, 1, prediction originally issued (perf counting only).
- ghr, output, H, current global history; LSB = newest outcome.

Behaviour:
- Reset (reset=1 at an edge):
  - Every counter loads WNT = 2^(N-1)-1; for N=1 this is 0.
  - ghr=0, pred_valid=0, prediction=0, pred_index=0.
  - Reset takes priority over lookup and update in the same cycle.
  - Reset mid-operation discards any in-flight lookup: pred_valid=0 on the next cycle.
- Index computation (combinational):
  - idx = lookup_pc[ADDR_BITS-1:0] XOR {zero-extended ghr} when MODE=1.
  - idx = lookup_pc[ADDR_BITS-1:0] when MODE=0.
  - Upper PC bits are ignored.
- Lookup, latency 1:
  - On an edge with lookup_valid=1: pred_valid<=1, pred_index<=idx, prediction<=table[idx][N-1].
  - If lookup_valid=0: pred_valid<=0; prediction and pred_index hold their values.
  - A lookup may be issued every cycle.
- Update (on an edge with upd_valid=1):
  - upd_taken=1: table[upd_index] increments, saturating at 2^N-1.
  - upd_taken=0: table[upd_index] decrements, saturating at 0.
  - GHR: ghr <= {ghr[H-2:0], upd_taken}. For H=1, ghr <= upd_taken.
  - The GHR is non-speculative: it shifts only on update.
- Simultaneous lookup and update in the same cycle:
  - The lookup reads the pre-update counter value, even when idx == upd_index.
  - The lookup hashes the pre-shift ghr.
  - The new counter and GHR values are visible from the next cycle.
- Only one entry is written per cycle. Entries other than upd_index are unchanged.
- No X propagation: all storage is reset.

Optional Feature:
- Macro: BHT_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs perf_lookups[31:0] and perf_mispredicts[31:0], both reset to 0.
  - perf_lookups increments on each accepted lookup_valid.
  - perf_mispredicts increments on each upd_valid with upd_pred != upd_taken.
  - Both counters wrap modulo 2^32.
- When undefined: the ports and logic are absent, and core behaviour is identical.

Test Plan:
- Reset with M=16, N=2:
  - Stimulus: reset 1 cycle, then lookup every pc 0..15.
  - Required: pred_valid=1 one cycle after each request, prediction=0 for all (counter=1), ghr=0.
- Saturation with N=2, MODE=0:
  - Stimulus: 4 updates at index 3, taken=1.
  - Required: lookup pc=3 predicts 1 after the 1st update (counter 1->2); counter stays 3 after the 2nd.
  - Stimulus: then 2 not-taken updates.
  - Required: counter 1, prediction 0. 5 further not-taken updates leave the counter at 0.
- Gshare hashing with MODE=1, H=4:
  - Stimulus: updates with taken 1,0,1,1.
  - Required: ghr=4'b1011. Lookup pc=9'h005 gives pred_index=5^11=14.
  - Stimulus: lookup pc=9'h1F5 (upper bits differ).
  - Required: same pred_index=14.
- Same-cycle collision:
  - Setup: counter[7]=1.
  - Stimulus: lookup idx 7 and update index 7 taken=1 in the same cycle.
  - Required: prediction=0 (old value). A lookup on the next cycle predicts 1.
- Reset mid-stream:
  - Stimulus: lookup_valid and reset asserted in the same cycle after training.
  - Required: pred_valid=0 next cycle; all entries back to WNT; ghr=0.
- N=1, M=8, with BHT_PERF_COUNTERS_EN defined:
  - Stimulus: 3 lookups; 2 updates with (upd_pred,upd_taken) = (0,1) and (1,1).
  - Required: perf_lookups=3, perf_mispredicts=1. The 1-bit counter follows the last outcome.
